// File: rtl/d_lsu.sv
// rtl/d_lsu.sv - data-side load/store unit
// Runs one RV32 memory op at a time over a simple rd/wr request bus.
module d_lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                done,
  output logic                err,
  output logic [XLEN-1:0]     ld_data,
  output logic [ADDR_LEN-1:0] addr,
  output logic                rd_req,
  output logic                wr_req,
  input  logic                rd_ready,
  input  logic                wr_ready,
  output logic [XLEN/8-1:0]   be,
  output logic [XLEN-1:0]     wr_data,
  input  logic [XLEN-1:0]     rd_data
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t                state;
  logic                  op_store;
  logic [2:0]            op_f3;
  logic [ADDR_LEN-1:0]   op_addr;
  logic [XLEN-1:0]       op_wdata;

  // Only the low ADDR_LEN address bits reach the bus.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_LEN];

  function automatic logic op_legal(input logic st, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok_code;
    logic ok_align;
    if (st) ok_code = (f3 < 3'd3);
    else    ok_code = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    case (f3[1:0])
      2'd1:    ok_align = ~a[0];
      2'd2:    ok_align = (a == 2'b00);
      default: ok_align = 1'b1;
    endcase
    return ok_code && ok_align;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [NB-1:0] m;
    case (f3[1:0])
      2'd0:    m = NB'(1) << a;
      2'd1:    m = NB'(3) << a;
      default: m = NB'(15);
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [XLEN-1:0] d);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    r = {{(XLEN-8){b[7]}}, b};
      3'd1:    r = {{(XLEN-16){h[15]}}, h};
      3'd4:    r = {{(XLEN-8){1'b0}}, b};
      3'd5:    r = {{(XLEN-16){1'b0}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Bus-facing address and data come from the captured op so they hold steady while waiting.
  assign addr = op_addr;

  always_comb begin
    wr_data = op_wdata;
    case (op_f3[1:0])
      2'd0:    wr_data = {NB{op_wdata[7:0]}};
      2'd1:    wr_data = {(NB/2){op_wdata[15:0]}};
      default: wr_data = op_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      be        <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      ld_data   <= '0;
      op_store  <= 1'b0;
      op_f3     <= 3'd0;
      op_addr   <= '0;
      op_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_store  <= req_store;
            op_f3     <= req_funct3;
            op_addr   <= req_addr[ADDR_LEN-1:0];
            op_wdata  <= req_wdata;
            req_ready <= 1'b0;
            if (!op_legal(req_store, req_funct3, req_addr[1:0])) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_store) begin
              state  <= S_WR;
              wr_req <= 1'b1;
              be     <= lane_mask(req_funct3, req_addr[1:0]);
            end else begin
              state  <= S_RD;
              rd_req <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (rd_ready) begin
            state   <= S_RESP;
            rd_req  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            ld_data <= load_extend(op_f3, op_addr[1:0], rd_data);
          end
        end
        S_WR: begin
          if (wr_ready) begin
            state  <= S_RESP;
            wr_req <= 1'b0;
            be     <= '0;
            done   <= 1'b1;
            err    <= 1'b0;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          rd_req    <= 1'b0;
          wr_req    <= 1'b0;
          be        <= '0;
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_lsu.sv
// tb/tb_d_lsu.sv - self-checking bench for d_lsu
// Transaction-level model plus directed ops with hand-computed results.
module tb_d_lsu;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        done;
  logic        err;
  logic [31:0] ld_data;
  logic [13:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic        rd_ready = 1'b0;
  logic        wr_ready = 1'b0;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [31:0] rd_data = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rdreq_cnt = 0;

  d_lsu #(.XLEN(32), .ADDR_LEN(14)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .ld_data(ld_data), .addr(addr),
    .rd_req(rd_req), .wr_req(wr_req), .rd_ready(rd_ready), .wr_ready(wr_ready),
    .be(be), .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit code_ok;
    code_ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return code_ok && ((a % sz(f3)) == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    int off;
    logic [31:0] v;
    off = int'(a % 4);
    if (sz(f3) == 4) return d;
    if (sz(f3) == 1) v = (d >> (8 * off)) & 32'hFF;
    else             v = (d >> (8 * off)) & 32'hFFFF;
    if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFFFF00;
    if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << sz(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (sz(f3) == 1) return {24'd0, d[7:0]} * 32'h01010101;
    if (sz(f3) == 2) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  // Model: one op in flight; done follows the bus handshake (or the accept, for errors).
  bit          m_busy = 1'b0;
  bit          m_bus = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_store = 1'b0;
  logic [2:0]  m_f3 = 3'd0;
  logic [31:0] m_addr = 32'd0;
  logic [3:0]  m_bev = 4'd0;
  logic [31:0] m_wdv = 32'd0;
  logic [31:0] m_ld = 32'd0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_busy <= 1'b0;
      m_bus  <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_ld   <= 32'd0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_bus) begin
      if (m_store ? wr_ready : rd_ready) begin
        m_bus  <= 1'b0;
        m_done <= 1'b1;
        m_err  <= 1'b0;
        if (!m_store) m_ld <= m_load(m_f3, m_addr, rd_data);
      end
    end else if (!m_busy && req_valid) begin
      m_busy  <= 1'b1;
      m_store <= req_store;
      m_f3    <= req_funct3;
      m_addr  <= req_addr;
      m_bev   <= m_be(req_funct3, req_addr);
      m_wdv   <= m_wd(req_funct3, req_wdata);
      if (m_legal(req_store, req_funct3, req_addr)) m_bus <= 1'b1;
      else begin
        m_done <= 1'b1;
        m_err  <= 1'b1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("rd_req", 32'(rd_req), 32'(m_bus && !m_store));
    chk("wr_req", 32'(wr_req), 32'(m_bus && m_store));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_done && m_err));
    chk("ld_data", ld_data, m_ld);
    chk("be", 32'(be), (m_bus && m_store) ? 32'(m_bev) : 32'd0);
    if (m_bus) begin
      chk("addr", 32'(addr), 32'(m_addr[13:0]));
      if (m_store) chk("wr_data", wr_data, m_wdv);
    end
    if (rd_req) rdreq_cnt <= rdreq_cnt + 1;
  end

  // Starts in an idle cycle just after a rising edge; returns in the next idle cycle.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv, input int dly,
                       input bit hold, output int lat, output int nrd,
                       output logic [3:0] be_s, output logic [31:0] wd_s);
    int c0;
    int r0;
    c0 = cyc;
    r0 = rdreq_cnt;
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk); #1;
    if (hold) begin
      req_addr = 32'h00003FFC;
      req_funct3 = 3'd7;
      req_wdata = 32'hFFFFFFFF;
    end else req_valid = 1'b0;
    be_s = be;
    wd_s = wr_data;
    if (m_legal(st, f3, a)) begin
      if (st) rd_ready = 1'b1; else wr_ready = 1'b1;
      repeat (dly) begin @(posedge clk); #1; end
      rd_data = rdv;
      rd_ready = !st;
      wr_ready = st;
      @(posedge clk); #1;
      rd_ready = 1'b0;
      wr_ready = 1'b0;
      rd_data = 32'h5A5A5A5A;
    end else begin
      rd_ready = 1'b1;
      wr_ready = 1'b1;
    end
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(done), 32'd1);
    lat = cyc - c0;
    req_valid = 1'b0;
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    @(posedge clk); #1;
    nrd = rdreq_cnt - r0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          nrd;
    logic [3:0]  b1;
    logic [31:0] w1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 1, 1'b0, lat, nrd, b1, w1);
    chk("lw_data", ld_data, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdreq_cycles", 32'(nrd), 32'd2);

    do_op(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF0000, 1, 1'b0, lat, nrd, b1, w1);
    chk("lb_data", ld_data, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF0000, 1, 1'b0, lat, nrd, b1, w1);
    chk("lbu_data", ld_data, 32'h00000080);
    do_op(1'b0, 3'd5, 32'h102, 32'd0, 32'h80FF0000, 2, 1'b0, lat, nrd, b1, w1);
    chk("lhu_data", ld_data, 32'h000080FF);
    do_op(1'b0, 3'd1, 32'h102, 32'd0, 32'h80FF0000, 1, 1'b0, lat, nrd, b1, w1);
    chk("lh_data", ld_data, 32'hFFFF80FF);

    do_op(1'b1, 3'd0, 32'h201, 32'h123456AB, 32'd0, 1, 1'b0, lat, nrd, b1, w1);
    chk("sb_be", 32'(b1), 32'h2);
    chk("sb_wdata", w1, 32'hABABABAB);
    chk("sb_lat", 32'(lat), 32'd3);
    do_op(1'b1, 3'd1, 32'h202, 32'h123456AB, 32'd0, 3, 1'b0, lat, nrd, b1, w1);
    chk("sh_be", 32'(b1), 32'hC);
    chk("sh_wdata", w1, 32'h56AB56AB);
    do_op(1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 32'd0, 1, 1'b0, lat, nrd, b1, w1);
    chk("sw_be", 32'(b1), 32'hF);
    chk("sw_wdata", w1, 32'hCAFEF00D);
    chk("ld_hold_after_store", ld_data, 32'hFFFF80FF);

    do_op(1'b0, 3'd2, 32'h102, 32'd0, 32'd0, 1, 1'b0, lat, nrd, b1, w1);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_rdreq", 32'(nrd), 32'd0);
    chk("lw_mis_ld_hold", ld_data, 32'hFFFF80FF);
    do_op(1'b1, 3'd1, 32'h101, 32'h1111, 32'd0, 1, 1'b0, lat, nrd, b1, w1);
    chk("sh_mis_lat", 32'(lat), 32'd1);
    do_op(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 1, 1'b0, lat, nrd, b1, w1);
    chk("ld_f3_3_lat", 32'(lat), 32'd1);
    do_op(1'b1, 3'd4, 32'h100, 32'd0, 32'd0, 1, 1'b0, lat, nrd, b1, w1);
    chk("st_f3_4_lat", 32'(lat), 32'd1);

    rd_ready = 1'b1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 3'd2, 32'h3F0, 32'd0, 32'h01234567, 5, 1'b1, lat, nrd, b1, w1);
    chk("io_rdreq_cycles", 32'(nrd), 32'd6);
    chk("io_lat", 32'(lat), 32'd7);
    chk("io_data", ld_data, 32'h01234567);

    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'h300;
    req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_req_before_rst", 32'(wr_req), 32'd1);
    @(posedge clk); #3;
    rstb = 1'b0;
    #1;
    chk("rst_async_wr_req", 32'(wr_req), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    chk("rst_async_ld_data", ld_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    do_op(1'b0, 3'd2, 32'h104, 32'd0, 32'h13579BDF, 1, 1'b0, lat, nrd, b1, w1);
    chk("post_rst_lw_data", ld_data, 32'h13579BDF);
    chk("post_rst_lw_lat", 32'(lat), 32'd3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
